// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the narrow-to-wide packing FIFO.
package fifo_pkg;

  // Bit offset of a packer lane inside the wide word for the chosen lane order.
  function automatic int lane_lsb(input int lane, input int in_w, input int ratio,
                                  input int lsb_first);
    return (lsb_first != 0) ? lane * in_w : (ratio - 1 - lane) * in_w;
  endfunction

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic accept;
    logic commit;
    logic drop;
  } pk_evt_t;

endpackage

// File: rtl/wconv_packer.sv
// Lane register and fill counter that assemble RATIO narrow words into one wide word,
// with zero-padded flush and a single-cycle commit strobe toward storage.
module wconv_packer
  import fifo_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int RATIO     = 2,
  parameter int LSB_FIRST = 0,
  parameter int OUT_W     = IN_W * RATIO,
  parameter int LANE_W    = $clog2(RATIO)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IN_W-1:0]   wr_data,
  input  logic              flush,
  input  logic              full,
  input  logic              room,
  output logic              commit,
  output logic              drop,
  output logic [OUT_W-1:0]  commit_data,
  output logic [LANE_W-1:0] lane_fill
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  logic [OUT_W-1:0]  lanes_q, lanes_d;
  logic [LANE_W-1:0] fill_q, fill_d;
  pk_evt_t           evt;

  always_comb begin
    evt        = '0;
    lanes_d    = lanes_q;
    fill_d     = fill_q;
    evt.accept = wr_en && !full;
    evt.drop   = wr_en && full;
    if (evt.accept) begin
      for (int i = 0; i < RATIO; i++) begin
        if (fill_q == LANE_W'(i)) lanes_d[lane_lsb(i, IN_W, RATIO, LSB_FIRST) +: IN_W] = wr_data;
      end
      if (fill_q == LAST_LANE) evt.commit = 1'b1;
      else                     fill_d     = fill_q + LANE_W'(1);
    end
    // Flush sees the same-cycle write already merged; with no room the packer keeps its lanes.
    if (flush && !evt.commit && (evt.accept || fill_q != '0)) begin
      if (room) evt.commit = 1'b1;
      else      evt.drop   = 1'b1;
    end
    commit_data = lanes_d;
    // Clearing on commit is what zero-pads the unfilled lanes of the next flushed word.
    if (evt.commit) begin
      lanes_d = '0;
      fill_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q <= '0;
      fill_q  <= '0;
    end else begin
      lanes_q <= lanes_d;
      fill_q  <= fill_d;
    end
  end

  assign commit    = evt.commit;
  assign drop      = evt.drop;
  assign lane_fill = fill_q;

endmodule

// File: rtl/fifo_width_upsize.sv
// Synchronous FIFO packing RATIO narrow writes into each wide read word, with flush,
// occupancy level and sticky overflow/underflow flags.
module fifo_width_upsize
  import fifo_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int RATIO     = 2,
  parameter int DEPTH     = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [IN_W-1:0]            wr_data,
  input  logic                       flush,
  output logic                       full,
  input  logic                       rd_en,
  output logic [IN_W*RATIO-1:0]      rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(RATIO)-1:0]   lane_fill,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int OUT_W  = IN_W * RATIO;
  localparam int LANE_W = $clog2(RATIO);
  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int LVL_W  = level_w(DEPTH);

  logic [OUT_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [OUT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             pop, room, commit, drop;
  logic [OUT_W-1:0] commit_data;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(DEPTH)) && (lane_fill == LANE_W'(RATIO - 1));
  assign pop   = rd_en && !empty;
  // A pop in the same cycle frees the slot a flush commit needs.
  assign room  = (level_q != LVL_W'(DEPTH)) || pop;

  wconv_packer #(
    .IN_W      (IN_W),
    .RATIO     (RATIO),
    .LSB_FIRST (LSB_FIRST),
    .OUT_W     (OUT_W),
    .LANE_W    (LANE_W)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .flush       (flush),
    .full        (full),
    .room        (room),
    .commit      (commit),
    .drop        (drop),
    .commit_data (commit_data),
    .lane_fill   (lane_fill)
  );

  always_comb begin
    wr_ptr_d    = commit ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    rd_data_d   = pop ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d  = pop;
    overflow_d  = overflow_q || drop;
    underflow_d = underflow_q || (rd_en && empty);
    level_d     = level_q;
    unique case ({commit, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage holds data only; occupancy is tracked by pointers and level.
  always_ff @(posedge clk) begin
    if (commit) mem_q[wr_ptr_q] <= commit_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
